// File: rtl/palindrome_pkg.sv
// Shared types and sizing helpers for the sequential palindrome checker.
package palindrome_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIND = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } pal_state_t;

    function automatic int calc_n(input int width, input int sym);
        return width / sym;
    endfunction

    // One extra bit so that len can hold N itself.
    function automatic int calc_lw(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/palindrome_sym_sel.sv
// Two-port symbol selector: picks the symbols at lo_idx and hi_idx from the operand.
module palindrome_sym_sel #(
    parameter int WIDTH = 32,
    parameter int SYM   = 1,
    parameter int LW    = 6
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [LW-1:0]    lo_idx,
    input  logic [LW-1:0]    hi_idx,
    output logic [SYM-1:0]   sym_lo,
    output logic [SYM-1:0]   sym_hi
);

    assign sym_lo = operand[32'(lo_idx) * SYM +: SYM];
    assign sym_hi = operand[32'(hi_idx) * SYM +: SYM];

endmodule

// File: rtl/seq_palindrome_checker.sv
// Symbol-wise palindrome checker: one pair per clock from both ends, with
// optional stripping of leading zero symbols and a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// FIND  | walking hi down past leading zero symbols (mode 1 only)
// CMP   | comparing sym[lo] against sym[hi], early exit on mismatch
// DONE  | result valid for one cycle; a new start is accepted here
module seq_palindrome_checker
    import palindrome_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SYM   = 1,
    parameter int LW    = calc_lw(calc_n(WIDTH, SYM))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic             is_pal,
    output logic [LW-1:0]    len
);

    localparam int N = calc_n(WIDTH, SYM);

    pal_state_t       state;
    logic [WIDTH-1:0] a_reg;
    logic [LW-1:0]    lo;
    logic [LW-1:0]    hi;
    logic [SYM-1:0]   sym_lo;
    logic [SYM-1:0]   sym_hi;

    palindrome_sym_sel #(
        .WIDTH (WIDTH),
        .SYM   (SYM),
        .LW    (LW)
    ) u_sym_sel (
        .operand (a_reg),
        .lo_idx  (lo),
        .hi_idx  (hi),
        .sym_lo  (sym_lo),
        .sym_hi  (sym_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            is_pal <= 1'b0;
            len    <= '0;
            lo     <= '0;
            hi     <= '0;
            a_reg  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg  <= A;
                        lo     <= '0;
                        hi     <= LW'(N - 1);
                        is_pal <= 1'b0;
                        len    <= mode ? '0 : LW'(N);
                        busy   <= 1'b1;
                        state  <= mode ? FIND : CMP;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                FIND: begin
                    // A zero operand stops at hi=0 and is checked as one symbol.
                    if (sym_hi == '0 && hi != '0) begin
                        hi <= hi - LW'(1);
                    end else begin
                        len   <= hi + LW'(1);
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (lo >= hi) begin
                        is_pal <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (sym_lo != sym_hi) begin
                        is_pal <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        lo <= lo + LW'(1);
                        hi <= hi - LW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
